// File: rtl/excess3_to_bcd_deser.sv
// ---------------------------------------------------------------------------
// excess3_to_bcd_deser
//
// Purpose: accepts one Excess-3 coded digit per input transfer, range-checks
// it, converts it to BCD (code - 3) and shifts it into an NDIGITS-wide packed
// BCD word. The completed word is offered on the output together with a
// sticky error flag that covers every digit of that word.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     input digit valid
//   in_ready     block can accept a digit (depends on state only)
//   in[3:0]      Excess-3 coded digit
//   out_valid    packed BCD word available
//   out_ready    downstream accepts the word
//   out[4N-1:0]  packed BCD word; out[3:0] is the last digit received
//   err          at least one invalid code in the word; qualified by out_valid
//   o_dbg_state  current FSM state (0 = COLLECT, 1 = HOLD)
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. A producer holds valid (and its data) until that edge; ready
// never depends combinationally on valid, so there is no same-cycle path from
// in/in_valid to any output.
// ---------------------------------------------------------------------------
module excess3_to_bcd_deser #(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NDIGITS-1:0]   out,
    output logic                   err,
    output logic                   o_dbg_state
);

    localparam int W     = 4 * NDIGITS;
    localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NDIGITS - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_shift;
    logic             r_err_acc;
    logic [W-1:0]     r_out;
    logic             r_err;

    logic             w_accept;
    logic             w_out_hs;
    logic             w_last;
    logic             w_code_ok;
    logic [3:0]       w_digit;
    logic [W-1:0]     w_shift_next;

    // Excess-3 digits occupy codes 3..12; anything else decodes to 0 and
    // marks the word as bad.
    assign w_code_ok = (in >= 4'h3) && (in <= 4'hC);
    assign w_digit   = w_code_ok ? (in - 4'h3) : 4'h0;

    // Shift left by one nibble; written without a part-select so that
    // NDIGITS = 1 (nothing to keep) needs no special case.
    assign w_shift_next = (r_shift << 4) | W'(w_digit);

    assign w_last   = (r_cnt == LAST_IDX);
    assign w_accept = in_valid && in_ready;
    assign w_out_hs = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and state-decoded handshake outputs
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && w_last) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = COLLECT;
                end
            end
            default: begin
                w_next_state = COLLECT;
            end
        endcase
    end

    // Datapath: digit counter, shift register, error accumulator, output word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            r_err_acc <= 1'b0;
            r_out     <= '0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_shift <= w_shift_next;
            if (w_last) begin
                r_cnt     <= '0;
                r_out     <= w_shift_next;
                // Include the final digit's own error, which is not yet in
                // the accumulator.
                r_err     <= r_err_acc | ~w_code_ok;
                r_err_acc <= 1'b0;
            end else begin
                r_cnt     <= r_cnt + CNT_W'(1);
                r_err_acc <= r_err_acc | ~w_code_ok;
            end
        end else if (w_out_hs) begin
            // Start the next word from a clean slate; out/err keep their
            // value until the next word completes.
            r_shift   <= '0;
            r_err_acc <= 1'b0;
        end
    end

    assign out         = r_out;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_excess3_to_bcd_deser.sv
// ---------------------------------------------------------------------------
// tb_excess3_to_bcd_deser
//
// Drives an NDIGITS=4 instance with directed and randomized Excess-3 words
// and an NDIGITS=1 instance with every code. Expected words come from an
// arithmetic model of the decode rules and are queued in exp_q.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_excess3_to_bcd_deser;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT (NDIGITS = 4) ----------------
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    din;
  logic          out_valid;
  logic          out_ready;
  logic [4*N-1:0] dout;
  logic          err;
  logic          dbg_state;

  excess3_to_bcd_deser #(.NDIGITS(N)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in         (din),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (dout),
    .err        (err),
    .o_dbg_state(dbg_state)
  );

  // ---------------- DUT (NDIGITS = 1) ----------------
  logic       in1_valid;
  logic       in1_ready;
  logic [3:0] din1;
  logic       out1_valid;
  logic       out1_ready;
  logic [3:0] dout1;
  logic       err1;
  logic       dbg1_state;

  excess3_to_bcd_deser #(.NDIGITS(1)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in1_valid),
    .in_ready   (in1_ready),
    .in         (din1),
    .out_valid  (out1_valid),
    .out_ready  (out1_ready),
    .out        (dout1),
    .err        (err1),
    .o_dbg_state(dbg1_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [4*N:0] exp_q[$];   // {err, out}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each code maps to code-3 when 3..12, else 0 plus an error;
  // the word is the digits read as base-16 with the first digit most
  // significant.
  function automatic logic [4*N:0] model_word(input logic [3:0] c[N]);
    int val = 0;
    bit e = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (int'(c[i]) >= 3 && int'(c[i]) <= 12) begin
        val = val * 16 + (int'(c[i]) - 3);
      end else begin
        val = val * 16;
        e = 1'b1;
      end
    end
    return {e, val[4*N-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Called on a falling edge; returns on the falling edge after the accept.
  task automatic send_digit(input logic [3:0] code, input int gap_max);
    int g;
    int n;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (g) @(negedge clk);
    in_valid = 1'b1;
    din      = code;
    n        = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Checks the word one cycle after the final accept; with out_ready high
  // also checks that out_valid lasted exactly one cycle.
  task automatic expect_word(input string tag);
    logic [4*N:0] e;
    e = exp_q.pop_front();
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_out"},   {16'd0, dout},      {16'd0, e[4*N-1:0]});
    check({tag, "_err"},   {31'd0, err},       {31'd0, e[4*N]});
    if (out_ready) begin
      @(negedge clk);
      check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_ready_back"}, {31'd0, in_ready},  32'd1);
    end
  endtask

  task automatic send_word(input logic [3:0] c[N], input int gap_max, input string tag);
    exp_q.push_back(model_word(c));
    for (int i = 0; i < N; i++) send_digit(c[i], gap_max);
    expect_word(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out"},      {16'd0, dout},      32'd0);
    check({tag, "_err"},      {31'd0, err},       32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready},  32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] c[N];
    logic [3:0] e1;

    in_valid   = 1'b0;
    din        = 4'h0;
    out_ready  = 1'b1;
    in1_valid  = 1'b0;
    din1       = 4'h0;
    out1_ready = 1'b1;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);

    check_reset_values("reset");
    check("reset1_out_valid", {31'd0, out1_valid}, 32'd0);
    check("reset1_in_ready",  {31'd0, in1_ready},  32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed words
    c = '{4'h4, 4'h8, 4'hC, 4'h3};
    send_word(c, 0, "dir_a");
    check("dir_a_const", {16'd0, dout}, 32'h1590);
    c = '{4'h4, 4'hE, 4'hC, 4'h3};
    send_word(c, 0, "dir_b");
    check("dir_b_const", {16'd0, dout}, 32'h1090);
    check("dir_b_errc",  {31'd0, err},  32'd1);
    c = '{4'h3, 4'h3, 4'h3, 4'h3};
    send_word(c, 0, "dir_c");
    check("dir_c_errc",  {31'd0, err},  32'd0);

    // Every code in every position, other positions random valid codes
    for (int p = 0; p < N; p++) begin
      for (int code = 0; code < 16; code++) begin
        for (int j = 0; j < N; j++) c[j] = 4'($urandom_range(12, 3));
        c[p] = 4'(code);
        send_word(c, 0, "exh");
      end
    end

    // Random codes with random idle gaps between digits
    for (int w = 0; w < 20; w++) begin
      for (int j = 0; j < N; j++) c[j] = 4'($urandom_range(15, 0));
      send_word(c, 3, "gap");
    end

    // Backpressure: word held while in_valid stays high with code 9
    out_ready = 1'b0;
    c = '{4'h5, 4'h6, 4'h7, 4'h8};
    for (int i = 0; i < N; i++) send_digit(c[i], 0);
    in_valid = 1'b1;
    din      = 4'h9;
    for (int k = 0; k < 10; k++) begin
      check("bp_valid",    {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready},  32'd0);
      check("bp_out",      {16'd0, dout},      32'h2345);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_back", {31'd0, in_ready},  32'd1);
    check("bp_valid_drop", {31'd0, out_valid}, 32'd0);
    check("bp_out_kept",   {16'd0, dout},      32'h2345);
    c = '{4'h9, 4'hA, 4'hB, 4'hC};
    exp_q.push_back(model_word(c));
    @(negedge clk);           // held 4'h9 accepted as digit 0 at this edge
    in_valid = 1'b0;
    for (int i = 1; i < N; i++) send_digit(c[i], 0);
    expect_word("bp_next");

    // Reset mid-word
    c = '{4'h4, 4'h5, 4'h6, 4'h7};
    send_word(c, 0, "pre_rst");
    send_digit(4'hB, 0);
    send_digit(4'hF, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    c = '{4'h3, 4'h3, 4'h3, 4'h4};
    send_word(c, 0, "post_rst_mid");

    // Reset during HOLD
    out_ready = 1'b0;
    c = '{4'hC, 4'hF, 4'hC, 4'hC};
    send_word(c, 0, "hold_word");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    c = '{4'h7, 4'h8, 4'h9, 4'hA};
    send_word(c, 1, "post_rst_hold");

    // NDIGITS = 1: every code goes straight to HOLD
    for (int code = 0; code < 16; code++) begin
      e1 = (code >= 3 && code <= 12) ? 4'(code - 3) : 4'h0;
      in1_valid = 1'b1;
      din1      = 4'(code);
      check("n1_in_ready", {31'd0, in1_ready}, 32'd1);
      @(negedge clk);
      in1_valid = 1'b0;
      check("n1_valid", {31'd0, out1_valid}, 32'd1);
      check("n1_out",   {28'd0, dout1},      {28'd0, e1});
      check("n1_err",   {31'd0, err1},       (code >= 3 && code <= 12) ? 32'd0 : 32'd1);
      @(negedge clk);
      check("n1_valid_drop", {31'd0, out1_valid}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
